// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the fetch stage: sequential fetch, stall, redirect, call/return via a circular RAS.
// All outputs registered (one-cycle latency); every redirect loads pc_out and pulses flush for one FLUSH cycle.
module fetch_sequencer #(
   parameter int PC_WIDTH   = 19,
   parameter int IMEM_DEPTH = 256,
   parameter int RAS_DEPTH  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_target,
   input  logic                call_valid,
   input  logic [PC_WIDTH-1:0] call_ret_addr,
   input  logic                ret_valid,
   input  logic                halt_req,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic                fetch_en,
   output logic                flush,
   output logic [1:0]          state,
   output logic                halted,
   output logic                ras_overflow,
   output logic                ras_underflow
);

   localparam int SPW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [PC_WIDTH-1:0] ADDR_MASK = PC_WIDTH'(IMEM_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      FLUSH = 2'b10,
      HALT  = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                fetch_en_q, fetch_en_d;
   logic                flush_q, flush_d;
   logic                halted_q, halted_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [PC_WIDTH-1:0] ras_d [RAS_DEPTH];
   logic [SPW-1:0]      sp_q, sp_d;
   logic [SPW:0]        cnt_q, cnt_d;
   logic [SPW-1:0]      sp_inc, sp_dec;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fetch_en_d = 1'b0;
      flush_d    = 1'b0;
      halted_d   = 1'b0;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      ras_d      = ras_q;
      sp_d       = sp_q;
      cnt_d      = cnt_q;
      // sp_q is the next write slot; the stack wraps so a full push overwrites the oldest entry
      sp_inc = (sp_q == SPW'(RAS_DEPTH - 1)) ? '0 : sp_q + 1'b1;
      sp_dec = (sp_q == '0) ? SPW'(RAS_DEPTH - 1) : sp_q - 1'b1;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               fetch_en_d = 1'b1;
            end
         end
         HALT: begin
            halted_d = 1'b1;
            if (start) begin
               state_d    = RUN;
               fetch_en_d = 1'b1;
               halted_d   = 1'b0;
            end
         end
         default: begin
            if (halt_req) begin
               state_d  = HALT;
               halted_d = 1'b1;
            end else if (ret_valid) begin
               state_d = FLUSH;
               flush_d = 1'b1;
               if (cnt_q == '0) begin
                  unf_d = 1'b1;
                  pc_d  = '0;
               end else begin
                  pc_d  = ras_q[sp_dec] & ADDR_MASK;
                  sp_d  = sp_dec;
                  cnt_d = cnt_q - 1'b1;
               end
            end else if (call_valid) begin
               state_d      = FLUSH;
               flush_d      = 1'b1;
               pc_d         = redirect_target & ADDR_MASK;
               ras_d[sp_q]  = call_ret_addr & ADDR_MASK;
               sp_d         = sp_inc;
               if (cnt_q == (SPW+1)'(RAS_DEPTH)) ovf_d = 1'b1;
               else                              cnt_d = cnt_q + 1'b1;
            end else if (redirect_valid) begin
               state_d = FLUSH;
               flush_d = 1'b1;
               pc_d    = redirect_target & ADDR_MASK;
            end else if (state_q == FLUSH) begin
               // leaving FLUSH fetches the freshly loaded PC without incrementing
               state_d    = RUN;
               fetch_en_d = 1'b1;
            end else if (!stall) begin
               pc_d       = (pc_q + 1'b1) & ADDR_MASK;
               fetch_en_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         fetch_en_q <= 1'b0;
         flush_q    <= 1'b0;
         halted_q   <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         sp_q       <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fetch_en_q <= fetch_en_d;
         flush_q    <= flush_d;
         halted_q   <= halted_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         sp_q       <= sp_d;
         cnt_q      <= cnt_d;
         ras_q      <= ras_d;
      end
   end

   assign pc_out        = pc_q;
   assign fetch_en      = fetch_en_q;
   assign flush         = flush_q;
   assign state         = state_q;
   assign halted        = halted_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: linear steps, immediate assertions against hand-computed values.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, stall, redirect_valid, call_valid, ret_valid, halt_req;
   logic [18:0] redirect_target, call_ret_addr;
   logic [18:0] pc_out;
   logic        fetch_en, flush, halted, ras_overflow, ras_underflow;
   logic [1:0]  state;

   int vectors    = 0;
   int miscompares = 0;

   fetch_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .call_valid(call_valid), .call_ret_addr(call_ret_addr),
      .ret_valid(ret_valid), .halt_req(halt_req),
      .pc_out(pc_out), .fetch_en(fetch_en), .flush(flush), .state(state),
      .halted(halted), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [18:0] pc, input logic fe,
                          input logic fl, input logic [1:0] st, input logic hl);
      chk({tag, ".pc"},     32'(pc_out),   32'(pc));
      chk({tag, ".fe"},     32'(fetch_en), 32'(fe));
      chk({tag, ".flush"},  32'(flush),    32'(fl));
      chk({tag, ".state"},  32'(state),    32'(st));
      chk({tag, ".halted"}, 32'(halted),   32'(hl));
   endtask

   initial begin
      reset = 1'b0; start = 0; stall = 0; redirect_valid = 0; call_valid = 0;
      ret_valid = 0; halt_req = 0; redirect_target = '0; call_ret_addr = '0;
      step(); step();
      chk_all("reset", 19'd0, 0, 0, 2'b00, 0);
      chk("reset.ovf", 32'(ras_overflow), 0);
      chk("reset.unf", 32'(ras_underflow), 0);
      reset = 1'b1;

      // IDLE ignores everything but start
      redirect_valid = 1; redirect_target = 19'd5;
      step();
      chk_all("idle_ignore", 19'd0, 0, 0, 2'b00, 0);
      redirect_valid = 0;

      start = 1;
      step();
      chk_all("start", 19'd0, 1, 0, 2'b01, 0);
      start = 0;
      for (int i = 1; i < 256; i++) begin
         step();
         chk("inc.pc", 32'(pc_out), 32'(i));
         chk("inc.fe", 32'(fetch_en), 1);
      end
      step();
      chk_all("wrap", 19'd0, 1, 0, 2'b01, 0);

      for (int i = 0; i < 10; i++) step();
      chk("pc10", 32'(pc_out), 10);
      redirect_valid = 1; redirect_target = 19'h00080;
      step();
      redirect_valid = 0;
      chk_all("redir", 19'h80, 0, 1, 2'b10, 0);
      step();
      chk_all("redir_exit", 19'h80, 1, 0, 2'b01, 0);
      step();
      chk_all("redir_inc", 19'h81, 1, 0, 2'b01, 0);

      redirect_valid = 1; redirect_target = 19'h7FF05;
      step();
      redirect_valid = 0;
      chk_all("mask", 19'h05, 0, 1, 2'b10, 0);
      step();
      chk_all("mask_exit", 19'h05, 1, 0, 2'b01, 0);

      // five calls into a four-entry stack, then five returns
      call_valid = 1; redirect_target = 19'h30;
      for (int i = 1; i <= 5; i++) begin
         call_ret_addr = 19'(i);
         step();
         chk_all("call", 19'h30, 0, 1, 2'b10, 0);
         chk("call.ovf", 32'(ras_overflow), (i == 5) ? 1 : 0);
      end
      call_valid = 0; ret_valid = 1;
      step(); chk_all("ret5", 19'd5, 0, 1, 2'b10, 0);
      step(); chk_all("ret4", 19'd4, 0, 1, 2'b10, 0);
      step(); chk_all("ret3", 19'd3, 0, 1, 2'b10, 0);
      step(); chk_all("ret2", 19'd2, 0, 1, 2'b10, 0);
      chk("ret2.unf", 32'(ras_underflow), 0);
      step(); chk_all("ret_empty", 19'd0, 0, 1, 2'b10, 0);
      chk("ret_empty.unf", 32'(ras_underflow), 1);
      ret_valid = 0;
      step();
      chk_all("ret_exit", 19'd0, 1, 0, 2'b01, 0);

      for (int i = 0; i < 20; i++) step();
      chk("pc20", 32'(pc_out), 20);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("stall", 19'd20, 0, 0, 2'b01, 0);
      end
      redirect_valid = 1; redirect_target = 19'd40;
      step();
      redirect_valid = 0; stall = 0;
      chk_all("stall_redir", 19'd40, 0, 1, 2'b10, 0);
      step();
      chk_all("stall_redir_exit", 19'd40, 1, 0, 2'b01, 0);
      step();
      chk_all("stall_redir_inc", 19'd41, 1, 0, 2'b01, 0);

      call_valid = 1; redirect_target = 19'h60; call_ret_addr = 19'h11;
      step();
      call_valid = 0;
      chk_all("call2", 19'h60, 0, 1, 2'b10, 0);
      step();
      chk_all("call2_exit", 19'h60, 1, 0, 2'b01, 0);
      halt_req = 1; ret_valid = 1;
      step();
      halt_req = 0; ret_valid = 0;
      chk_all("halt_ret", 19'h60, 0, 0, 2'b11, 1);
      redirect_valid = 1; redirect_target = 19'h22;
      step();
      redirect_valid = 0;
      chk_all("halt_hold", 19'h60, 0, 0, 2'b11, 1);
      start = 1;
      step();
      start = 0;
      chk_all("resume", 19'h60, 1, 0, 2'b01, 0);
      ret_valid = 1;
      step();
      ret_valid = 0;
      chk_all("ret_after_halt", 19'h11, 0, 1, 2'b10, 0);
      chk("sticky.unf", 32'(ras_underflow), 1);
      chk("sticky.ovf", 32'(ras_overflow), 1);

      // asynchronous reset while in FLUSH, checked before the next edge
      #2 reset = 1'b0;
      #1;
      chk_all("async_rst", 19'd0, 0, 0, 2'b00, 0);
      chk("async_rst.ovf", 32'(ras_overflow), 0);
      chk("async_rst.unf", 32'(ras_underflow), 0);
      step();
      reset = 1'b1;
      start = 1;
      step();
      start = 0;
      chk_all("restart", 19'd0, 1, 0, 2'b01, 0);
      ret_valid = 1;
      step();
      ret_valid = 0;
      chk_all("ret_cleared_stack", 19'd0, 0, 1, 2'b10, 0);
      chk("ret_cleared_stack.unf", 32'(ras_underflow), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the program counter that drives the instruction-fetch stage of the 19-bit CPU. It sequences sequential fetch, stalls, taken branches and jumps, and call/return through a small return-address stack. On every redirect it produces a one-cycle flush so the in-flight fetched instruction is discarded. pc_out feeds the fetch stage's program-counter input directly.

Parameters:
PC_WIDTH, 19, width of pc_out, targets and return addresses
IMEM_DEPTH, 256, instruction memory depth; PC arithmetic is modulo this value (power of two)
RAS_DEPTH, 4, return-address stack entries

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  leave IDLE or HALT and begin or resume fetching
stall  in  1  hold PC, suppress fetch_en
redirect_valid  in  1  taken branch or jump from execute
redirect_target  in  PC_WIDTH  target for redirect and call
call_valid  in  1  call: push call_ret_addr, jump to redirect_target
call_ret_addr  in  PC_WIDTH  return address to push
ret_valid  in  1  return: pop stack, jump to popped address
halt_req  in  1  stop fetching
pc_out  out  PC_WIDTH  registered fetch address
fetch_en  out  1  fetch stage should latch pc_out this cycle
flush  out  1  one-cycle pulse: discard the in-flight instruction
state  out  2  IDLE=00, RUN=01, FLUSH=10, HALT=11
halted  out  1  high in HALT
ras_overflow  out  1  sticky: push while stack full
ras_underflow  out  1  sticky: pop while stack empty

Behaviour:
- Reset (reset=0, async): pc_out=0, fetch_en=0, flush=0, state=IDLE, halted=0, stack empty, both sticky flags=0. All outputs registered. Every change is visible one cycle after the sampling edge.
- Address rule: any value loaded into pc_out is taken modulo IMEM_DEPTH. Bits above log2(IMEM_DEPTH) are forced to 0. Increment wraps IMEM_DEPTH-1 to 0.
- IDLE: fetch_en=0, PC held. start=1 moves to RUN. All other inputs are ignored.
- RUN: events are resolved each cycle in this priority order: halt_req > ret_valid > call_valid > redirect_valid > stall > increment.
  - halt_req: move to HALT, PC held, fetch_en=0.
  - ret_valid: pop the stack; pc_out <= popped address; flush=1; move to FLUSH.
  - ret_valid on an empty stack: set ras_underflow; pc_out <= 0; flush=1; move to FLUSH.
  - call_valid: push call_ret_addr; pc_out <= redirect_target; flush=1; move to FLUSH.
  - call_valid on a full stack: drop the oldest entry (circular), keep the newest RAS_DEPTH entries, set ras_overflow.
  - redirect_valid: pc_out <= redirect_target; flush=1; move to FLUSH.
  - stall: PC held, fetch_en=0. A redirect, call or return overrides stall.
  - No event: pc_out <= pc_out+1, fetch_en=1.
- Simultaneous events: ret_valid together with call_valid performs the return only; no push occurs. A lower-priority event is dropped, not queued.
- FLUSH: lasts one cycle; fetch_en=0; flush returns to 0 on the next edge unless re-asserted.
  - A redirect, call or return arriving in FLUSH is accepted with the same rules as RUN: PC updated, flush pulses again, stay in FLUSH one more cycle.
  - halt_req in FLUSH moves to HALT.
  - With no event, FLUSH moves to RUN and fetches the loaded PC. That PC is not incremented on FLUSH exit.
- HALT: fetch_en=0, halted=1, PC and stack held. start=1 moves to RUN and resumes at the held PC. All other inputs are ignored.
- Sticky flags are cleared only by reset.
- Reset asserted mid-operation: immediate return to reset values regardless of state. The stack contents are invalidated.

Test Plan:
- Reset then start, no events -> RUN; pc_out 0,1,2,... with fetch_en=1. After 256 increments pc_out wraps 255 -> 0.
- RUN at pc=10, redirect_valid with target 0x00080 -> next cycle pc_out=0x80, flush=1, state=FLUSH, fetch_en=0. Following cycle RUN, fetch_en=1, pc_out=0x80. Then 0x81.
- Redirect target 0x7FF05 -> pc_out=0x05; upper bits masked.
- Five calls (ret addrs 1..5), then five returns -> pops 5,4,3,2. ras_overflow=1 after the fifth call. The fifth return underflows: ras_underflow=1, pc_out=0.
- stall held 3 cycles at pc=20 -> pc_out=20, fetch_en=0 throughout. stall+redirect (target 40) in the same cycle -> redirect taken. halt_req+ret_valid in the same cycle -> HALT with stack unchanged.
- Reset deasserted-then-asserted asynchronously while in FLUSH -> all outputs 0 and state IDLE before the next clock edge.
